// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock line FIFO.
// Level arithmetic is done at a fixed wide width so any ADDR_WIDTH fits.
package fifo_pkg;

  localparam int unsigned FIFO_STD   = 0;
  localparam int unsigned FIFO_FWFT  = 1;
  localparam int unsigned FIFO_LVL_W = 32;

  typedef logic [FIFO_LVL_W-1:0] fifo_lvl_t;

  typedef struct packed {
    logic almost_full;
    logic almost_empty;
  } fifo_almost_t;

  function automatic fifo_almost_t fifo_almost_flags(input fifo_lvl_t lvl,
                                                     input fifo_lvl_t afull_thresh,
                                                     input fifo_lvl_t aempty_thresh);
    fifo_almost_t f;
    f.almost_full  = (lvl >= afull_thresh);
    f.almost_empty = (lvl <= aempty_thresh);
    return f;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-before-write).
// The read register has a synchronous clear so the FIFO output starts at zero.
module fifo_sdp_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_line_fifo.sv
// Single-clock line FIFO with standard or first-word-fall-through read,
// exact level, programmable almost flags, flush and sticky error flags.
module sync_line_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned FWFT       = FIFO_STD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  input  logic [ADDR_WIDTH:0]   afull_thresh,
  input  logic [ADDR_WIDTH:0]   aempty_thresh,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t DEPTH_LVL = ptr_t'(DEPTH);

  ptr_t wr_ptr, rd_ptr, lvl_q;
  ptr_t wr_ptr_next, rd_ptr_next, lvl_next;
  logic full_q, empty_q, afull_q, aempty_q, rd_valid_q, ovf_q, udf_q;
  logic wr_acc, rd_acc, ovf_ev, udf_ev;

  logic                  ram_we, ram_re;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  byp_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  fifo_almost_t almost_next, almost_rst;

  always_comb begin
    wr_acc      = wr_en && !full_q && !flush;
    rd_acc      = rd_en && !empty_q && !flush;
    ovf_ev      = wr_en && full_q && !flush;
    udf_ev      = rd_en && empty_q && !flush;
    wr_ptr_next = wr_ptr + ptr_t'(wr_acc);
    rd_ptr_next = rd_ptr + ptr_t'(rd_acc);
    lvl_next    = lvl_q + ptr_t'(wr_acc) - ptr_t'(rd_acc);
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      lvl_next    = '0;
    end
    almost_next = fifo_almost_flags(fifo_lvl_t'(lvl_next), fifo_lvl_t'(afull_thresh),
                                    fifo_lvl_t'(aempty_thresh));
    almost_rst  = fifo_almost_flags('0, fifo_lvl_t'(afull_thresh),
                                    fifo_lvl_t'(aempty_thresh));
  end

  // FWFT keeps the RAM read register pointed at the post-edge head every cycle,
  // so the next word is already presented when the head is popped.
  always_comb begin
    ram_we = wr_acc && rst_n;
    if (FWFT == FIFO_FWFT) begin
      ram_re    = !flush;
      ram_raddr = rd_ptr_next[ADDR_WIDTH-1:0];
    end else begin
      ram_re    = rd_acc;
      ram_raddr = rd_ptr[ADDR_WIDTH-1:0];
    end
  end

  fifo_sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lvl_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= almost_rst.almost_full;
      aempty_q   <= 1'b1;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      lvl_q      <= lvl_next;
      full_q     <= (lvl_next == DEPTH_LVL);
      empty_q    <= (lvl_next == '0);
      afull_q    <= almost_next.almost_full;
      aempty_q   <= almost_next.almost_empty;
      rd_valid_q <= (FWFT == FIFO_FWFT) ? (lvl_next != '0) : rd_acc;
      ovf_q      <= ovf_ev || (ovf_q && !clr_err);
      udf_q      <= udf_ev || (udf_q && !clr_err);
      // A word written into the head slot this edge is not yet visible in the
      // RAM read register, so it is forwarded for one cycle.
      if (FWFT == FIFO_FWFT && !flush) begin
        byp_q      <= wr_acc && (wr_ptr == rd_ptr_next);
        byp_data_q <= wr_data;
      end
    end
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign level        = lvl_q;
  assign rd_valid     = rd_valid_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign rd_data      = byp_q ? byp_data_q : ram_rdata;

endmodule

// File: tb/tb_sync_line_fifo.sv
// Bench for sync_line_fifo: standard and FWFT instances share stimulus and are
// compared against a queue-based reference model, plus a directed vector table.
module tb_sync_line_fifo;
  import fifo_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [AW:0]   afull_thresh = 4'd6;
  logic [AW:0]   aempty_thresh = 4'd1;

  logic          s_full, s_af, s_empty, s_ae, s_valid, s_ovf, s_udf;
  logic [DW-1:0] s_data;
  logic [AW:0]   s_level;
  logic          f_full, f_af, f_empty, f_ae, f_valid, f_ovf, f_udf;
  logic [DW-1:0] f_data;
  logic [AW:0]   f_level;

  always #5 clk = ~clk;

  sync_line_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FIFO_STD)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(s_full), .almost_full(s_af), .rd_en(rd_en), .rd_data(s_data),
    .rd_valid(s_valid), .empty(s_empty), .almost_empty(s_ae), .level(s_level),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
    .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err)
  );

  sync_line_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FIFO_FWFT)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .full(f_full), .almost_full(f_af), .rd_en(rd_en), .rd_data(f_data),
    .rd_valid(f_valid), .empty(f_empty), .almost_empty(f_ae), .level(f_level),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
    .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, flags derived from its size.
  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0, m_udf = 1'b0, m_svld = 1'b0, m_af = 1'b0, m_ae = 1'b1;
  logic [DW-1:0] m_sdata = '0;

  task automatic model_edge();
    int pre;
    if (!rst_n) begin
      q.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_svld  = 1'b0;
      m_sdata = '0;
    end else begin
      pre   = q.size();
      m_ovf = (wr_en && !flush && pre == DEPTH) || (m_ovf && !clr_err);
      m_udf = (rd_en && !flush && pre == 0) || (m_udf && !clr_err);
      if (flush) begin
        q.delete();
        m_svld = 1'b0;
      end else begin
        m_svld = rd_en && pre > 0;
        if (m_svld) m_sdata = q.pop_front();
        if (wr_en && pre < DEPTH) q.push_back(wr_data);
      end
    end
    m_af = q.size() >= int'(afull_thresh);
    m_ae = q.size() <= int'(aempty_thresh);
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("std_level", 32'(s_level), n);
    chk("std_full", 32'(s_full), 32'(n == DEPTH));
    chk("std_empty", 32'(s_empty), 32'(n == 0));
    chk("std_afull", 32'(s_af), 32'(m_af));
    chk("std_aempty", 32'(s_ae), 32'(m_ae));
    chk("std_ovf", 32'(s_ovf), 32'(m_ovf));
    chk("std_udf", 32'(s_udf), 32'(m_udf));
    chk("std_valid", 32'(s_valid), 32'(m_svld));
    chk("std_data", 32'(s_data), 32'(m_sdata));
    chk("fwft_level", 32'(f_level), n);
    chk("fwft_full", 32'(f_full), 32'(n == DEPTH));
    chk("fwft_empty", 32'(f_empty), 32'(n == 0));
    chk("fwft_afull", 32'(f_af), 32'(m_af));
    chk("fwft_aempty", 32'(f_ae), 32'(m_ae));
    chk("fwft_ovf", 32'(f_ovf), 32'(m_ovf));
    chk("fwft_udf", 32'(f_udf), 32'(m_udf));
    chk("fwft_valid", 32'(f_valid), 32'(n > 0));
    if (n > 0) chk("fwft_data", 32'(f_data), 32'(q[0]));
    else if (!rst_n) chk("fwft_rst_data", 32'(f_data), 32'h0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic fl, input logic w, input logic rd,
                       input logic c, input logic [DW-1:0] d);
    rst_n   = r;
    flush   = fl;
    wr_en   = w;
    rd_en   = rd;
    clr_err = c;
    wr_data = d;
  endtask

  typedef struct {
    logic          rst_n, flush, wr, rd, clr;
    logic [DW-1:0] din;
    logic [AW:0]   exp_level;
    logic          exp_full, exp_empty, exp_ovf, exp_udf, exp_vld;
    logic [DW-1:0] exp_data;
  } vec_t;

  function automatic vec_t mk(logic r, logic fl, logic w, logic rd, logic c, logic [DW-1:0] d,
                              logic [AW:0] lv, logic fu, logic em, logic ov, logic ud,
                              logic vl, logic [DW-1:0] dt);
    vec_t v;
    v.rst_n = r; v.flush = fl; v.wr = w; v.rd = rd; v.clr = c; v.din = d;
    v.exp_level = lv; v.exp_full = fu; v.exp_empty = em; v.exp_ovf = ov;
    v.exp_udf = ud; v.exp_vld = vl; v.exp_data = dt;
    return v;
  endfunction

  vec_t vecs[25];

  initial begin
    // Standard-mode directed table: fill, overflow, drain, flush, error clear.
    vecs[0] = mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000);
    for (int k = 1; k <= 8; k++)
      vecs[k] = mk(1, 0, 1, 0, 0, 16'(k), 4'(k), k == 8, 0, 0, 0, 0, 16'h0000);
    vecs[9]  = mk(1, 0, 1, 0, 0, 16'hDEAD, 8, 1, 0, 1, 0, 0, 16'h0000);
    vecs[10] = mk(1, 0, 0, 1, 0, 16'h0000, 7, 0, 0, 1, 0, 1, 16'h0001);
    vecs[11] = mk(1, 0, 1, 1, 0, 16'h0009, 7, 0, 0, 1, 0, 1, 16'h0002);
    vecs[12] = mk(1, 1, 1, 0, 0, 16'h0BAD, 0, 0, 1, 1, 0, 0, 16'h0002);
    vecs[13] = mk(1, 0, 0, 1, 0, 16'h0000, 0, 0, 1, 1, 1, 0, 16'h0002);
    vecs[14] = mk(1, 0, 0, 1, 1, 16'h0000, 0, 0, 1, 0, 1, 0, 16'h0002);
    vecs[15] = mk(1, 0, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0002);
    for (int k = 16; k < 24; k++)
      vecs[k] = mk(1, 0, 1, 0, 0, 16'(k - 15), 4'(k - 15), k == 23, 0, 0, 0, 0, 16'h0002);
    vecs[24] = mk(1, 0, 0, 1, 0, 16'h0000, 7, 0, 0, 0, 0, 1, 16'h0001);

    afull_thresh  = 4'd6;
    aempty_thresh = 4'd1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].flush, vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
      step();
      chk("tbl_level", 32'(s_level), 32'(vecs[i].exp_level));
      chk("tbl_full", 32'(s_full), 32'(vecs[i].exp_full));
      chk("tbl_empty", 32'(s_empty), 32'(vecs[i].exp_empty));
      chk("tbl_ovf", 32'(s_ovf), 32'(vecs[i].exp_ovf));
      chk("tbl_udf", 32'(s_udf), 32'(vecs[i].exp_udf));
      chk("tbl_valid", 32'(s_valid), 32'(vecs[i].exp_vld));
      chk("tbl_data", 32'(s_data), 32'(vecs[i].exp_data));
    end
    for (int k = 2; k <= 8; k++) begin
      drive(1, 0, 0, 1, 0, '0);
      step();
      chk("drain_order", 32'(s_data), 32'(k));
    end
    chk("drain_empty", 32'(s_empty), 32'h1);

    // FWFT: single write shows next cycle, pop empties.
    drive(1, 0, 1, 0, 0, 16'h00AA);
    step();
    chk("fwft_lat_valid", 32'(f_valid), 32'h1);
    chk("fwft_lat_data", 32'(f_data), 32'h00AA);
    drive(1, 0, 0, 1, 0, '0);
    step();
    chk("fwft_pop_empty", 32'(f_empty), 32'h1);

    // FWFT: four back-to-back pops with no bubble.
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 1, 0, 0, 16'(16'h0010 + k));
      step();
    end
    for (int k = 0; k < 4; k++) begin
      chk("fwft_b2b_valid", 32'(f_valid), 32'h1);
      chk("fwft_b2b_data", 32'(f_data), 32'(16'h0010 + k));
      drive(1, 0, 0, 1, 0, '0);
      step();
    end
    chk("fwft_b2b_empty", 32'(f_empty), 32'h1);

    // Simultaneous read/write at level 4 for 20 cycles (pointers wrap).
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 1, 0, 0, 16'(16'h0100 + k));
      step();
    end
    for (int k = 0; k < 20; k++) begin
      drive(1, 0, 1, 1, 0, 16'($urandom));
      step();
      chk("rw_level4", 32'(s_level), 32'h4);
    end

    // Threshold sweep 0..8, then read+write at full.
    drive(1, 1, 0, 0, 0, '0);
    step();
    for (int k = 1; k <= 8; k++) begin
      drive(1, 0, 1, 0, 0, 16'($urandom));
      step();
      chk("afull_sweep", 32'(s_af), 32'(k >= 6));
      chk("aempty_sweep", 32'(s_ae), 32'(k <= 1));
    end
    drive(1, 0, 1, 1, 0, 16'hBEEF);
    step();
    chk("full_rw_level", 32'(s_level), 32'h7);
    chk("full_rw_ovf", 32'(s_ovf), 32'h1);

    // Flush at level 5 with a write: overflow must survive.
    drive(1, 0, 0, 1, 0, '0);
    step();
    step();
    chk("pre_flush_level", 32'(s_level), 32'h5);
    drive(1, 1, 1, 0, 0, 16'h5555);
    step();
    chk("flush_level", 32'(s_level), 32'h0);
    chk("flush_empty", 32'(f_empty), 32'h1);
    chk("flush_ovf_kept", 32'(s_ovf), 32'h1);

    // Underflow, then reset mid-burst at level 3.
    drive(1, 0, 0, 1, 1, '0);
    step();
    chk("udf_set", 32'(s_udf), 32'h1);
    chk("ovf_cleared", 32'(s_ovf), 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 1, 0, 0, 16'(16'h0300 + k));
      step();
    end
    drive(0, 0, 1, 1, 0, 16'h7777);
    step();
    chk("rst_level", 32'(s_level), 32'h0);
    chk("rst_udf", 32'(f_udf), 32'h0);
    chk("rst_fwft_valid", 32'(f_valid), 32'h0);
    chk("rst_std_data", 32'(s_data), 32'h0);
    chk("rst_aempty", 32'(f_ae), 32'h1);

    // Randomised traffic including threshold changes, flushes and resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 3) begin
        afull_thresh  = 4'($urandom_range(0, 15));
        aempty_thresh = 4'($urandom_range(0, 15));
      end
      drive($urandom_range(0, 99) >= 1, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 5, 16'($urandom));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_line_fifo.md
Name: sync_line_fifo

Overview:
- Parametrised single-clock FIFO for the next generation of line buffering between the SDRAM arbiter and the VGA/BEV pixel pipeline, used where both sides share one clock.
- Configurable width and depth, plus two read modes: standard (registered read) and first-word-fall-through (FWFT).
- Provides an exact fill level, programmable almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 16, word width in bits.
- ADDR_WIDTH, 8, log2 of depth; DEPTH = 2**ADDR_WIDTH words total capacity in both modes.
- FWFT, 0, 0 = standard read (data one cycle after rd_en), 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- full  out  1  no space; writes ignored.
- almost_full  out  1  level >= afull_thresh.
- rd_en  in  1  read request (standard) / pop (FWFT).
- rd_data  out  DATA_WIDTH  read word.
- rd_valid  out  1  rd_data holds a valid word.
- empty  out  1  no readable word.
- almost_empty  out  1  level <= aempty_thresh.
- level  out  ADDR_WIDTH+1  words held, 0..DEPTH.
- afull_thresh  in  ADDR_WIDTH+1  almost-full threshold, quasi-static.
- aempty_thresh  in  ADDR_WIDTH+1  almost-empty threshold, quasi-static.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  clears overflow/underflow.

Behaviour:
- Clock and reset: single clock, reset is synchronous and active-low.
- Reset values: level=0, empty=1, full=0, almost_empty=1 when aempty_thresh >= 0 (always true), almost_full=(afull_thresh==0), rd_valid=0, rd_data=0, overflow=0, underflow=0. Pointers are 0.
- Storage: DEPTH x DATA_WIDTH array with binary pointers of ADDR_WIDTH+1 bits. Pointers wrap modulo 2*DEPTH; the MSB distinguishes full from empty.
- Write accepted: wr_en && !full, evaluating full from the registered state at that edge. A write while full is dropped and sets overflow.
- Read accepted: rd_en && !empty. A read while empty sets underflow with no pointer change.
- Simultaneous read and write:
  - When not full and not empty: both are accepted and level is unchanged.
  - At full: the write is rejected even if a read is accepted in the same cycle.
  - At empty: the read is rejected and the write is accepted.
- level, full (level==DEPTH), empty and the almost flags are all registered and derived from the post-edge level. Each reflects an accepted operation one cycle later.
- Standard mode (FWFT=0):
  - rd_data is registered from the memory on an accepted read; rd_valid=1 in the following cycle only.
  - rd_data holds its last value otherwise.
- FWFT mode (FWFT=1):
  - Uses a one-word output stage counted in level.
  - rd_valid = !empty; rd_data shows the head word whenever rd_valid=1.
  - rd_en pops the head; the next word, if any, is shown in the following cycle with no bubble.
  - Latency from a write into an empty FIFO to rd_valid=1 is 1 cycle.
- flush:
  - Sets pointers to 0, level=0, empty=1, full=0 and rd_valid=0.
  - Takes priority over wr_en/rd_en in the same cycle; neither operation takes effect and neither sets an error flag.
  - Does not clear overflow/underflow and does not reset rd_data.
- Error flags:
  - clr_err clears overflow/underflow.
  - If a new error event coincides with clr_err, the flag stays set (set wins).
- rst_n has priority over flush and over all other inputs. Asserting reset mid-burst discards all contents, with the defined reset values on the next edge.
- Thresholds:
  - Compared unsigned at full ADDR_WIDTH+1 width.
  - afull_thresh > DEPTH means almost_full never asserts.
  - Threshold changes take effect in the next cycle.

Decomposition:
- Package fifo_pkg: typedef for level/pointer width, a function that computes the almost flags, and FIFO mode constants FIFO_STD=0 and FIFO_FWFT=1.
- Sub-module fifo_sdp_ram: simple dual-port RAM, one write port and one registered read port, DATA_WIDTH x DEPTH, inferable as block RAM.
- The top block holds pointers, level, flags and the FWFT output stage.

Test Plan:
- Standard mode, DATA_WIDTH=16, ADDR_WIDTH=3:
  - Write 0x0001..0x0008 -> full=1 at cycle after 8th write, level=8.
  - 9th write 0xDEAD -> overflow=1, level stays 8.
  - Read 8 -> rd_valid one cycle after each rd_en, data 0x0001..0x0008 in order, empty=1 after.
- FWFT mode, depth 8:
  - Single write 0x00AA to empty -> rd_valid=1, rd_data=0x00AA next cycle.
  - Pop with no write -> empty=1 next cycle.
  - Back-to-back pops on 4 stored words -> 4 consecutive valid cycles, no bubble.
- Simultaneous operations:
  - Read and write every cycle at level 4 for 20 cycles -> level constant 4, pointers wrap past 16, data order preserved.
  - At full: rd_en and wr_en together -> level 7, overflow=1.
- Thresholds: afull_thresh=6, aempty_thresh=1.
  - Fill 0..8 -> almost_full asserts at level 6.
  - almost_empty deasserts at level 2.
- Flush at level 5 together with wr_en -> level=0, empty=1, overflow unchanged.
- Errors and reset:
  - Read on empty -> underflow=1.
  - clr_err -> cleared next cycle.
  - rst_n=0 mid-burst at level 3 -> all outputs take their reset values at the next edge.
